sdram_uart_tx: RTL and testbench

//  Downstream consumer of the SDRAM read-side FIFO: when readback is enabled, pops 16-bit words

---
 rtl/sdram_uart_tx_if.sv | 29 ++
 rtl/sdram_uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_sdram_uart_tx.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_uart_tx_if.sv
// ============================================================================
// Module  : sdram_uart_tx_if
// Brief   : Read-FIFO handshake and UART pin bundle for sdram_uart_tx.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface sdram_uart_tx_if;
    logic        TX_EN;
    logic        RD_EMPTY;
    logic [15:0] RD_FIFO_DATA;
    logic        RD_FIFO_REQ;
    logic        UART_TXD;
    logic        TX_BUSY;

    // FIFO-controller / host side
    modport master (
        output TX_EN, RD_EMPTY, RD_FIFO_DATA,
        input  RD_FIFO_REQ, UART_TXD, TX_BUSY
    );

    // Transmitter side
    modport slave (
        input  TX_EN, RD_EMPTY, RD_FIFO_DATA,
        output RD_FIFO_REQ, UART_TXD, TX_BUSY
    );
endinterface

`default_nettype wire

// File: rtl/sdram_uart_tx.sv
// ============================================================================
// Module  : sdram_uart_tx
// Brief   : Pops 16-bit words from the SDRAM read FIFO and sends each as two
//           UART bytes (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter bit HI_FIRST = 1'b1
) (
    input  wire logic      CLK_50M,
    input  wire logic      RST_N,
    sdram_uart_tx_if.slave bus
);

    localparam int c_BAUD_DIV = CLK_FREQ / BAUD;
    localparam int c_CNT_W    = (c_BAUD_DIV > 1) ? $clog2(c_BAUD_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(c_BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_WAIT   = 3'd2,
        S_LATCH  = 3'd3,
        S_START  = 3'd4,
        S_DATA   = 3'd5,
        S_STOP   = 3'd6
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd7
`endif
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_ten_sync;
    logic [1:0]           r_emp_sync;
    logic [c_CNT_W-1:0]   r_baud_cnt;
    logic [2:0]           r_bit_cnt;
    logic                 r_byte_sel;
    logic [15:0]          r_hold;

    logic                 w_ten;
    logic                 w_emp;
    logic                 w_baud_end;
    logic                 w_in_frame;
    logic [7:0]           w_byte;
    logic                 w_req;
    logic                 w_txd;
    logic                 w_busy;

    assign w_ten      = r_ten_sync[1];
    assign w_emp      = r_emp_sync[1];
    assign w_baud_end = (r_baud_cnt == c_BAUD_LAST);
    // byte_sel=0 picks the first byte on the wire, whichever half that is
    assign w_byte     = (r_byte_sel ^ !HI_FIRST) ? r_hold[7:0] : r_hold[15:8];

    always_comb begin
        w_in_frame = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
`ifdef UART_TX_PARITY_EN
        if (r_state == S_PARITY) begin
            w_in_frame = 1'b1;
        end
`endif
    end

    // TX_EN / RD_EMPTY partly originate in the 100 MHz domain
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_ten_sync <= 2'b00;
            r_emp_sync <= 2'b00;
        end else begin
            r_ten_sync <= {r_ten_sync[0], bus.TX_EN};
            r_emp_sync <= {r_emp_sync[0], bus.RD_EMPTY};
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_txd       = 1'b1;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_ten && !w_emp) begin
                    w_state_nxt = S_POP;
                end
            end
            S_POP: begin
                w_req       = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_state_nxt = S_START;
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_baud_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_txd = w_byte[r_bit_cnt];
                if (w_baud_end && (r_bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_txd = ^w_byte;
                if (w_baud_end) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_txd = 1'b1;
                if (w_baud_end) begin
                    w_state_nxt = r_byte_sel ? S_IDLE : S_START;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Baud counter restarts in LATCH and wraps at STOP end, so each START begins at 0
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_byte_sel <= 1'b0;
            r_hold     <= 16'h0000;
        end else begin
            if (w_in_frame) begin
                r_baud_cnt <= w_baud_end ? '0 : r_baud_cnt + 1'b1;
            end else begin
                r_baud_cnt <= '0;
            end

            if (r_state != S_DATA) begin
                r_bit_cnt <= 3'd0;
            end else if (w_baud_end) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (r_state == S_LATCH) begin
                r_hold     <= bus.RD_FIFO_DATA;
                r_byte_sel <= 1'b0;
            end else if ((r_state == S_STOP) && w_baud_end && !r_byte_sel) begin
                r_byte_sel <= 1'b1;
            end
        end
    end

    assign bus.RD_FIFO_REQ = w_req;
    assign bus.UART_TXD    = w_txd;
    assign bus.TX_BUSY     = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_sdram_uart_tx.sv
// ============================================================================
// Module  : tb_sdram_uart_tx
// Brief   : Self-checking bench for sdram_uart_tx with FIFO model and UART monitor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sdram_uart_tx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115200;
    localparam int BD       = CLK_FREQ / BAUD;
    localparam bit HI_FIRST = 1'b1;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WORD_CYC = 2 * FRAME_BITS * BD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    sdram_uart_tx_if bus ();

    sdram_uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .HI_FIRST (HI_FIRST)
    ) dut (
        .CLK_50M (clk),
        .RST_N   (rst_n),
        .bus     (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int pop_cnt      = 0;
    int underflow    = 0;
    int rst_events   = 0;
    int txd_low_cnt  = 0;

    logic [15:0] fifo_q[$];
    logic [8:0]  exp_q[$];   // {parity, byte}
    logic [9:0]  rx_q[$];    // {stop, parity, byte}

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_events <= rst_events + 1;

    // Non-show-ahead read FIFO: q updates after the pop cycle
    initial begin
        bus.RD_EMPTY     = 1'b1;
        bus.RD_FIFO_DATA = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.RD_FIFO_REQ === 1'b1) begin
                if (fifo_q.size() == 0) begin
                    underflow++;
                end else begin
                    bus.RD_FIFO_DATA = fifo_q.pop_front();
                    pop_cnt++;
                end
            end
            bus.RD_EMPTY = (fifo_q.size() == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.UART_TXD !== 1'b1) txd_low_cnt++;
        end
    end

    // UART receiver: mid-bit sampling, frame discarded if reset hits it
    initial begin
        logic [7:0] b;
        logic       p;
        logic       s;
        int         ev;
        int         idx;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.UART_TXD === 1'b0) begin
                ev      = rst_events;
                aborted = 1'b0;
                b = 8'h00; p = 1'b0; s = 1'b0;
                for (int k = 1; k <= (FRAME_BITS - 1) * BD + BD / 2; k++) begin
                    @(negedge clk);
                    if (rst_events != ev || rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k >= BD / 2 + BD && ((k - BD / 2) % BD) == 0) begin
                        idx = (k - BD / 2) / BD - 1;
                        if (idx < 8) b[idx] = bus.UART_TXD;
                        else if (idx == FRAME_BITS - 2) s = bus.UART_TXD;
                        else p = bus.UART_TXD;
                    end
                end
                if (!aborted) rx_q.push_back({s, p, b});
            end
        end
    end

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [15:0] w);
        logic [7:0] first;
        logic [7:0] second;
        first  = HI_FIRST ? w[15:8] : w[7:0];
        second = HI_FIRST ? w[7:0]  : w[15:8];
        fifo_q.push_back(w);
        exp_q.push_back({^first, first});
        exp_q.push_back({^second, second});
    endtask

    task automatic wait_req(input int max, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (bus.RD_FIFO_REQ === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_txd_low(input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (bus.UART_TXD === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (bus.TX_BUSY === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rx(input int cnt, input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            if (rx_q.size() >= cnt) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.TX_EN  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.TX_EN = 1'($urandom_range(0, 1));
            if (i == 10) fifo_q.push_back(16'h1234);
            if (i == 30) fifo_q.delete();
            tests_run++;
            if (bus.UART_TXD !== 1'b1 || bus.RD_FIFO_REQ !== 1'b0 || bus.TX_BUSY !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: txd=%b req=%b busy=%b, want 1/0/0",
                         i, bus.UART_TXD, bus.RD_FIFO_REQ, bus.TX_BUSY);
            end
        end
        bus.TX_EN = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++;
        if (pop_cnt !== 0 || underflow !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_pop: pops=%0d underflow=%0d, want 0/0", pop_cnt, underflow);
        end
    endtask

    task automatic test_single();
        bit         ok;
        int         n;
        int         p0;
        int         t_pop;
        int         t_start;
        logic [9:0] r;
        logic [8:0] e;
        p0 = pop_cnt;
        push_word(16'hA55A);
        bus.TX_EN = 1'b1;
        wait_req(20, ok, n);
        t_pop = cyc;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL single_pop: no RD_FIFO_REQ within 20 cycles, want a pulse");
        end
        @(negedge clk);
        tests_run++;
        if (bus.RD_FIFO_REQ !== 1'b0 || bus.TX_BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_req_pulse: req=%b busy=%b after pop, want 0/1",
                     bus.RD_FIFO_REQ, bus.TX_BUSY);
        end
        wait_txd_low(10, ok);
        t_start = cyc;
        tests_run++;
        if (!ok || (t_start - t_pop) != 3) begin
            tests_failed++;
            $display("FAIL single_start_latency: ok=%b pop->start=%0d cycles, want 3",
                     ok, t_start - t_pop);
        end
        wait_idle(WORD_CYC + 100, ok);
        tests_run++;
        if (!ok || (cyc - t_start) != WORD_CYC) begin
            tests_failed++;
            $display("FAIL single_word_time: ok=%b start->idle=%0d cycles, want %0d",
                     ok, cyc - t_start, WORD_CYC);
        end
        wait_rx(2, 1000, ok);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (!ok || rx_q.size() == 0 || exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL single_byte%0d: received %0d bytes, want 2", i, rx_q.size());
            end else begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                if (r[7:0] !== e[7:0] || r[9] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL single_byte%0d: got %02h stop=%b, want %02h stop=1",
                             i, r[7:0], r[9], e[7:0]);
                end
            end
        end
        tests_run++;
        if (pop_cnt - p0 !== 1) begin
            tests_failed++;
            $display("FAIL single_pop_count: pops=%0d, want 1", pop_cnt - p0);
        end
    endtask

    task automatic test_gating();
        bit         ok;
        int         n;
        int         p0;
        int         low0;
        logic [9:0] r;
        logic [8:0] e;
        bus.TX_EN = 1'b0;
        push_word(16'h3C81);
        p0   = pop_cnt;
        low0 = txd_low_cnt;
        repeat (10000) @(negedge clk);
        tests_run++;
        if (pop_cnt != p0 || txd_low_cnt != low0) begin
            tests_failed++;
            $display("FAIL gating_hold: pops=%0d txd_low_cycles=%0d, want 0/0",
                     pop_cnt - p0, txd_low_cnt - low0);
        end
        bus.TX_EN = 1'b1;
        wait_req(10, ok, n);
        tests_run++;
        if (!ok || n != 3) begin
            tests_failed++;
            $display("FAIL gating_latency: ok=%b enable->pop=%0d cycles, want 3", ok, n);
        end
        wait_idle(WORD_CYC + 100, ok);
        wait_rx(2, 1000, ok);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (!ok || rx_q.size() == 0 || exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL gating_byte%0d: received %0d bytes, want 2", i, rx_q.size());
            end else begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                if (r[7:0] !== e[7:0] || r[9] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL gating_byte%0d: got %02h stop=%b, want %02h stop=1",
                             i, r[7:0], r[9], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_stream();
        bit         ok;
        int         p0;
        logic [9:0] r;
        logic [8:0] e;
        p0 = pop_cnt;
        push_word(16'h0001);
        push_word(16'h0002);
        push_word(16'h0003);
        wait_rx(6, 3 * (WORD_CYC + 20) + 200, ok);
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (!ok || rx_q.size() == 0 || exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL stream_byte%0d: received %0d bytes, want 6", i, rx_q.size());
            end else begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                if (r[7:0] !== e[7:0] || r[9] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stream_byte%0d: got %02h stop=%b, want %02h stop=1",
                             i, r[7:0], r[9], e[7:0]);
                end
            end
        end
        wait_idle(2 * BD, ok);
        repeat (200) @(negedge clk);
        tests_run++;
        if (pop_cnt - p0 != 3 || underflow != 0 || bus.TX_BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_pops: pops=%0d underflow=%0d busy=%b, want 3/0/0",
                     pop_cnt - p0, underflow, bus.TX_BUSY);
        end
    endtask

    task automatic test_abort();
        bit         ok;
        int         p0;
        int         low0;
        logic [9:0] r;
        logic [8:0] e;
        push_word(16'hFFFF);
        wait_txd_low(40, ok);
        repeat (3 * BD) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (!ok || bus.UART_TXD !== 1'b1 || bus.TX_BUSY !== 1'b0 || bus.RD_FIFO_REQ !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_outputs: started=%b txd=%b busy=%b req=%b, want 1/1/0/0",
                     ok, bus.UART_TXD, bus.TX_BUSY, bus.RD_FIFO_REQ);
        end
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        p0   = pop_cnt;
        low0 = txd_low_cnt;
        repeat (2000) @(negedge clk);
        tests_run++;
        if (pop_cnt != p0 || txd_low_cnt != low0 || rx_q.size() != 0 || underflow != 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: pops=%0d txd_low=%0d rx=%0d underflow=%0d, want 0/0/0/0",
                     pop_cnt - p0, txd_low_cnt - low0, rx_q.size(), underflow);
        end
        push_word(16'h96C3);
        wait_rx(2, WORD_CYC + 200, ok);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (!ok || rx_q.size() == 0 || exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL abort_resume_byte%0d: received %0d bytes, want 2", i, rx_q.size());
            end else begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                if (r[7:0] !== e[7:0] || r[9] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL abort_resume_byte%0d: got %02h stop=%b, want %02h stop=1",
                             i, r[7:0], r[9], e[7:0]);
                end
            end
        end
        wait_idle(2 * BD, ok);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        bit         ok;
        int         t_start;
        logic [9:0] r;
        logic [1:0] want_par;
        want_par = 2'b01;   // 0x07 -> 1, 0x03 -> 0 (index 0 = first byte)
        exp_q.delete();
        fifo_q.push_back(16'h0703);
        wait_txd_low(40, ok);
        t_start = cyc;
        wait_idle(WORD_CYC + 100, ok);
        tests_run++;
        if (!ok || (cyc - t_start) != 2 * 4774) begin
            tests_failed++;
            $display("FAIL parity_word_time: start->idle=%0d cycles, want %0d",
                     cyc - t_start, 2 * 4774);
        end
        wait_rx(2, 1000, ok);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (!ok || rx_q.size() == 0) begin
                tests_failed++;
                $display("FAIL parity_byte%0d: received %0d bytes, want 2", i, rx_q.size());
            end else begin
                r = rx_q.pop_front();
                if (r[7:0] !== ((i == 0) ? 8'h07 : 8'h03) || r[8] !== want_par[i] || r[9] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL parity_byte%0d: got %02h par=%b stop=%b, want %02h par=%b stop=1",
                             i, r[7:0], r[8], r[9], (i == 0) ? 8'h07 : 8'h03, want_par[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_gating();
        test_stream();
        test_abort();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        tests_run++;
        if (exp_q.size() != 0 || rx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: expected left=%0d received left=%0d, want 0/0",
                     exp_q.size(), rx_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
